// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit: decodes width/alignment, runs single accesses
// against a word memory, merges sub-word stores via read-modify-write, extends loads.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic        mem_rvalid,
    input  logic        mem_waitreq
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      addr_q, wdata_q;
    logic [2:0]       f3_q;
    logic             accept;
    logic             ren_c, we_c;
    logic             req_bad_c;

    // Byte/half selection with sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'b0, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'b0, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace one byte or half lane of the read word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] m;
        m = w;
        if (f3 == 3'b000) m[{a, 3'b000} +: 8] = d[7:0];
        else              m[{a[1], 4'b0000} +: 16] = d[15:0];
        return m;
    endfunction

    // Illegal width codes and misaligned addresses never reach memory.
    always_comb begin
        req_bad_c = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_bad_c = 1'b1;
        if (req_store && req_funct3[2])
            req_bad_c = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_bad_c = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_bad_c = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        word_d  = word_q;
        accept  = 1'b0;
        ren_c   = 1'b0;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (req_bad_c) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!req_store) begin
                        state_d = LD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = ST;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD, RMW_RD: begin
                ren_c = 1'b1;
                if (mem_rvalid && !mem_waitreq) begin
                    if (state_q == LD) begin
                        rdata_d = load_extract(mem_rd, f3_q, addr_q[1:0]);
                        state_d = RESP;
                    end else begin
                        word_d  = mem_rd;
                        state_d = RMW_WR;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST, RMW_WR: begin
                we_c = 1'b1;
                if (!mem_waitreq) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and response flags are forced low while reset is held.
    always_comb begin
        busy       = (state_q != IDLE);
        mem_ren    = ren_c && !rst;
        mem_we     = we_c && !rst;
        resp_valid = (state_q == RESP) && !rst;
        resp_err   = (state_q == RESP) && err_q && !rst;
        resp_rdata = (state_q == RESP) ? rdata_q : '0;
        mem_addr   = '0;
        mem_wd     = '0;
        if (ren_c || we_c) mem_addr = {addr_q[31:2], 2'b00};
        if (state_q == ST)          mem_wd = wdata_q;
        else if (state_q == RMW_WR) mem_wd = store_merge(word_q, wdata_q, f3_q, addr_q[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            word_q  <= word_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory with stall injection and a
// byte-arithmetic reference model for loads, stores, errors and latency.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ren, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_rvalid, mem_waitreq;

    logic [31:0] mem [0:63];
    int          stall_left;
    logic        rvalid_en;

    int          n_tests, n_fail;
    int          ren_cyc, we_cyc, wr_done, both_cnt, idle_bad;
    logic [31:0] last_wr_addr;

    assign mem_rd      = mem[mem_addr[7:2]];
    assign mem_rvalid  = rvalid_en;
    assign mem_waitreq = (stall_left != 0);

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_rvalid(mem_rvalid), .mem_waitreq(mem_waitreq)
    );

    task automatic clear_counters();
        ren_cyc = 0; we_cyc = 0; wr_done = 0; both_cnt = 0; idle_bad = 0; last_wr_addr = '0;
    endtask

    // One clock: observe at negedge, let the edge pass, then apply memory effects.
    task automatic step(output logic rv, output logic [31:0] rd, output logic er);
        logic        do_wr, do_dec;
        logic [31:0] wa, wd;
        @(negedge clk);
        rv = resp_valid; rd = resp_rdata; er = resp_err;
        do_wr  = mem_we && !mem_waitreq;
        wa     = mem_addr;
        wd     = mem_wd;
        do_dec = (mem_ren || mem_we) && stall_left != 0;
        if (mem_ren) ren_cyc++;
        if (mem_we) we_cyc++;
        if (mem_ren && mem_we) both_cnt++;
        if (!mem_ren && !mem_we && (mem_addr != 0 || mem_wd != 0)) idle_bad++;
        @(posedge clk);
        #1;
        if (do_wr) begin
            mem[wa[7:2]] = wd;
            wr_done++;
            last_wr_addr = wa;
        end
        if (do_dec) stall_left--;
    endtask

    // Issue one request and wait (bounded) for its response; lat = cycles after acceptance.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int k, input logic rvok,
                          output int lat, output logic [31:0] rd, output logic er);
        logic        v, e;
        logic [31:0] d;
        clear_counters();
        stall_left = k;
        rvalid_en  = rvok;
        req_valid  = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 64 && lat < 0; n++) begin
            step(v, d, e);
            if (n == 0) req_valid = 1'b0;
            if (v) begin
                lat = n; rd = d; er = e;
            end
        end
        stall_left = 0;
        rvalid_en  = 1'b1;
    endtask

    // Reference: width rules and lane arithmetic straight from the ISA semantics.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] old, input int k,
                                  output logic err, output logic [31:0] rd,
                                  output logic [31:0] neww, output int lat,
                                  output int strobes, output int writes);
        int          nb, sh;
        logic        legal;
        logic [31:0] mask, v;
        nb = 1 << f3[1:0];
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal || (int'(a[2:0]) % nb != 0);
        rd = '0; neww = old; writes = 0; strobes = 0; lat = 1;
        if (!err) begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            sh = 8 * int'(a[1:0]);
            if (!st) begin
                v = (old >> sh) & mask;
                if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                rd = v; lat = 2 + k; strobes = 1 + k;
            end else begin
                neww = (old & ~(mask << sh)) | ((wd & mask) << sh);
                writes = 1;
                lat = (nb == 4) ? 2 + k : 3 + k;
                strobes = (nb == 4) ? 1 + k : 2 + k;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rvalid_en = 1'b1; stall_left = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_ren, mem_we, resp_valid, resp_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000", {mem_ren, mem_we, resp_valid, resp_err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b rdata=%h addr=%h wd=%h want 0", busy, resp_rdata, mem_addr, mem_wd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int          lat;
        logic [31:0] rd;
        logic        er;
        mem[4] = 32'hDEAD_BEEF;
        do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, lat, rd, er);
        n_tests++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_basic: lat=%0d rdata=%h err=%b want 2 deadbeef 0", lat, rd, er);
        end
        mem[4] = 32'h80FF_0000;
        do_txn(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b1, lat, rd, er);
        n_tests++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_sign: rdata=%h err=%b want ffffff80 0", rd, er);
        end
        do_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b1, lat, rd, er);
        n_tests++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lbu_zero: rdata=%h err=%b want 00000080 0", rd, er);
        end
        mem[8] = 32'hAABB_CCDD;
        do_txn(1'b1, 3'b001, 32'h22, 32'h1234, 0, 1'b1, lat, rd, er);
        n_tests++;
        if (mem[8] !== 32'h1234_CCDD || last_wr_addr !== 32'h20 || wr_done !== 1 || we_cyc !== 1
            || lat !== 3 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_rmw: word=%h addr=%h writes=%0d we=%0d lat=%0d err=%b want 1234ccdd 20 1 1 3 0",
                     mem[8], last_wr_addr, wr_done, we_cyc, lat, er);
        end
        do_txn(1'b0, 3'b010, 32'h06, 32'h0, 0, 1'b1, lat, rd, er);
        n_tests++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || ren_cyc !== 0 || we_cyc !== 0) begin
            n_fail++;
            $display("FAIL lw_misaligned: lat=%0d err=%b rdata=%h ren=%0d we=%0d want 1 1 0 0 0",
                     lat, er, rd, ren_cyc, we_cyc);
        end
    endtask

    task automatic test_timeout();
        int          lat;
        logic [31:0] rd;
        logic        er;
        do_txn(1'b0, 3'b010, 32'h40, 32'h0, 0, 1'b0, lat, rd, er);
        n_tests++;
        if (lat !== int'(TIMEOUT) + 1 || er !== 1'b1 || rd !== 32'h0 || ren_cyc !== int'(TIMEOUT)
            || we_cyc !== 0) begin
            n_fail++;
            $display("FAIL timeout: lat=%0d err=%b rdata=%h ren=%0d we=%0d want %0d 1 0 %0d 0",
                     lat, er, rd, ren_cyc, we_cyc, TIMEOUT + 1, TIMEOUT);
        end
    endtask

    // Back-to-back randomized accesses with random stalls, each checked against the model.
    task automatic test_random();
        int          lat, k, e_lat, e_str, e_wr;
        logic [31:0] rd, a, wd, old, e_rd, e_new;
        logic        er, st, e_err;
        logic [2:0]  f3;
        for (int t = 0; t < 80; t++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = 32'($urandom_range(0, 255));
            wd  = $urandom;
            k   = $urandom_range(0, 3);
            old = $urandom;
            mem[a[7:2]] = old;
            model(st, f3, a, wd, old, k, e_err, e_rd, e_new, e_lat, e_str, e_wr);
            do_txn(st, f3, a, wd, k, 1'b1, lat, rd, er);
            n_tests++;
            if (er !== e_err || rd !== e_rd || lat !== e_lat) begin
                n_fail++;
                $display("FAIL rand_resp[%0d] st=%b f3=%b a=%h: err=%b rdata=%h lat=%0d want %b %h %0d",
                         t, st, f3, a, er, rd, lat, e_err, e_rd, e_lat);
            end
            n_tests++;
            if (mem[a[7:2]] !== e_new || wr_done !== e_wr || (ren_cyc + we_cyc) !== e_str) begin
                n_fail++;
                $display("FAIL rand_mem[%0d] st=%b f3=%b a=%h: word=%h writes=%0d strobes=%0d want %h %0d %0d",
                         t, st, f3, a, mem[a[7:2]], wr_done, ren_cyc + we_cyc, e_new, e_wr, e_str);
            end
            n_tests++;
            if (both_cnt !== 0 || idle_bad !== 0) begin
                n_fail++;
                $display("FAIL rand_bus[%0d]: both=%0d idle_nonzero=%0d want 0 0", t, both_cnt, idle_bad);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic        v, e;
        logic [31:0] d;
        int          resp_cnt;
        clear_counters();
        rvalid_en = 1'b0;
        mem[16] = 32'h1122_3344;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h41; req_wdata = 32'hA5;
        step(v, d, e);
        req_valid = 1'b0;
        step(v, d, e);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_ren !== 1'b0 || mem_we !== 1'b0 || ren_cyc < 1) begin
            n_fail++;
            $display("FAIL rst_gate: ren=%b we=%b prior_ren=%0d want 0 0 >=1", mem_ren, mem_we, ren_cyc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rvalid_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        resp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(v, d, e);
            if (v) resp_cnt++;
        end
        n_tests++;
        if (resp_cnt !== 0 || wr_done !== 0 || we_cyc !== 0 || mem[16] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL rst_drop: resp=%0d writes=%0d we=%0d word=%h want 0 0 0 11223344",
                     resp_cnt, wr_done, we_cyc, mem[16]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
